// File: rtl/adder_arbiter.sv
// Round-robin sequencer sharing one external adder between requesters.
// Operands are registered onto the adder, the result captured one cycle later.
module adder_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_carry,
  output logic                     resp_valid,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_carry,
  input  logic                     resp_ready,
  output logic                     busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]               state;
  logic [ID_W-1:0]          last;
  logic [ID_W-1:0]          win;
  logic                     any;
  logic                     take;
  logic [NUM_REQ-1:0]       sh;
  logic [NUM_REQ*WIDTH-1:0] sa;
  logic [NUM_REQ*WIDTH-1:0] sb;
  int                       idx;

  // Search upward from last+1, wrapping, for the first valid requester.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    sh  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      sh  = req_valid >> idx;
      if (!any && sh[0]) begin
        any = 1'b1;
        win = ID_W'(idx);
      end
    end
  end

  assign take = any &&
    (state == IDLE || (state == RESP && resp_ready));

  assign sa = req_a >> (int'(win) * WIDTH);
  assign sb = req_b >> (int'(win) * WIDTH);

  always_comb begin
    req_ready = '0;
    if (take) req_ready = NUM_REQ'(1) << win;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= ID_W'(NUM_REQ - 1);
      add_a      <= '0;
      add_b      <= '0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_carry <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          resp_sum   <= add_sum;
          resp_carry <= add_carry;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A grant in RESP overrides the return to IDLE.
      if (take) begin
        add_a   <= sa[WIDTH-1:0];
        add_b   <= sb[WIDTH-1:0];
        resp_id <= win;
        last    <= win;
        state   <= ISSUE;
      end
    end
  end

endmodule
